vdrive_sequencer: RTL

Sequencer for the CCD vertical-drive timing path. On each `start` it optionally issues one sensor-gate (SG) transfer pulse, then clocks a programmable number of lines through the 4-phase vertical register. Each line uses an 8-step overlapping phase pattern, and every step lasts a programmable number of clocks. The block sits between the readout controller (which issues `start` and the configuration) and the vertical driver stage fed by the phase outputs.

---
 rtl/vdrive_sequencer_if.sv | 25 ++
 rtl/vdrive_sequencer.sv | 92 +++++++++
 2 files changed

// File: rtl/vdrive_sequencer_if.sv
// vdrive_sequencer_if: control/config and phase-drive bundle between readout controller and vertical-drive sequencer
interface vdrive_sequencer_if #(
    parameter int CW = 16,
    parameter int LW = 12
);
    logic          start;
    logic          abort;
    logic [LW-1:0] line_count;
    logic [CW-1:0] t_step;
    logic          sg_en;
    logic [CW-1:0] sg_width;
    logic [3:0]    v;
    logic          sg;
    logic          busy;
    logic          line_strobe;
    logic          done;
    modport master (
        output start, abort, line_count, t_step, sg_en, sg_width,
        input  v, sg, busy, line_strobe, done
    );
    modport slave (
        input  start, abort, line_count, t_step, sg_en, sg_width,
        output v, sg, busy, line_strobe, done
    );
endinterface

// File: rtl/vdrive_sequencer.sv
// vdrive_sequencer: optional SG pulse followed by N lines of 8-step 4-phase vertical clocking
module vdrive_sequencer #(
    parameter int CW = 16,
    parameter int LW = 12
) (
    input logic clk,
    input logic reset,
    vdrive_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SG, SHIFT} state_t;
    localparam logic [3:0] PAT [8] = '{4'b0011, 4'b0010, 4'b0110, 4'b0100,
                                       4'b1100, 4'b1000, 4'b1001, 4'b0001};
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, t_q, t_d, sgw_q, sgw_d;
    logic [2:0]    step_q, step_d;
    logic [LW-1:0] lines_q, lines_d;
    logic          done_d, step_end, sg_end, line_end;
    assign step_end        = cnt_q == t_q - CW'(1);
    assign sg_end          = cnt_q == sgw_q - CW'(1);
    assign line_end        = state_q == SHIFT && step_q == 3'd7 && step_end;
    assign bus.line_strobe = line_end;
    assign bus.busy        = state_q != IDLE;
    // next-state: frame launch, SG timing, step/line advance and abort
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        lines_d = lines_q;
        t_d     = t_q;
        sgw_d   = sgw_q;
        done_d  = 1'b0;
        if (bus.abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            step_d  = '0;
            lines_d = '0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    if (bus.line_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        t_d     = (bus.t_step == '0) ? CW'(1) : bus.t_step;
                        sgw_d   = (bus.sg_width == '0) ? CW'(1) : bus.sg_width;
                        lines_d = bus.line_count;
                        cnt_d   = '0;
                        step_d  = '0;
                        state_d = bus.sg_en ? SG : SHIFT;
                    end
                end
                SG: begin
                    cnt_d   = sg_end ? '0 : cnt_q + CW'(1);
                    state_d = sg_end ? SHIFT : SG;
                end
                SHIFT: begin
                    cnt_d  = step_end ? '0 : cnt_q + CW'(1);
                    step_d = step_end ? step_q + 3'd1 : step_q;
                    if (line_end) begin
                        lines_d = lines_q - LW'(1);
                        state_d = (lines_q == LW'(1)) ? IDLE : SHIFT;
                        done_d  = lines_q == LW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
    // state, counters, latched config and registered drive outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            step_q   <= '0;
            lines_q  <= '0;
            t_q      <= '0;
            sgw_q    <= '0;
            bus.v    <= 4'b0011;
            bus.sg   <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            lines_q  <= lines_d;
            t_q      <= t_d;
            sgw_q    <= sgw_d;
            bus.v    <= (state_d == SHIFT) ? PAT[step_d] : 4'b0011;
            bus.sg   <= state_d == SG;
            bus.done <= done_d;
        end
    end
endmodule
